// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg: FSM encodings and width helper shared by the APB command master
package apb_cmd_master_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: command FIFO with a registered full flag so the upstream ready is a flop
module apb_cmd_fifo
  import apb_cmd_master_pkg::*;
#(
  parameter int W     = 39,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PW = clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   cnt, cnt_nx;
  logic          do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign cnt_nx  = cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
  assign empty   = (cnt == '0);
  assign dout    = mem[rptr];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop) rptr <= rptr + PW'(1);
      cnt  <= cnt_nx;
      full <= (cnt_nx == (PW+1)'(DEPTH));
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB initiator running buffered valid/ready commands one transfer at a time
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int BUS_AW         = 6,
  parameter int BUS_DW         = 32,
  parameter int CMD_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_vld_i,
  output logic              cmd_rdy_o,
  input  logic              cmd_write_i,
  input  logic [BUS_AW-1:0] cmd_addr_i,
  input  logic [BUS_DW-1:0] cmd_wdata_i,
  output logic              rsp_vld_o,
  input  logic              rsp_rdy_i,
  output logic [BUS_DW-1:0] rsp_rdata_o,
  output logic              rsp_timeout_o,
  output logic [BUS_AW-1:0] apb_paddr_m,
  output logic              apb_pwrite_m,
  output logic              apb_psel_m,
  output logic              apb_penable_m,
  output logic [BUS_DW-1:0] apb_pwdata_m,
  input  logic [BUS_DW-1:0] apb_prdata_m,
  input  logic              apb_pready_m
);
  localparam int CW = 1 + BUS_AW + BUS_DW;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] head;
  logic          empty, full, pop, load, tmo;
  assign pop       = (state == ST_IDLE) | ((state == ST_RESP) & rsp_rdy_i);
  assign load      = pop & ~empty;
  assign tmo       = (TIMEOUT_CYCLES != 0) && (tcnt == T_LAST);
  assign cmd_rdy_o = ~full;
  apb_cmd_fifo #(.W(CW), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push   (cmd_vld_i),
    .din    ({cmd_write_i, cmd_addr_i, cmd_wdata_i}),
    .pop    (pop),
    .dout   (head),
    .empty  (empty),
    .full   (full)
  );
  // The bus registers lag the state by one edge: ACCESS first raises penable, then samples pready.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= ST_IDLE;
      tcnt          <= '0;
      apb_paddr_m   <= '0;
      apb_pwrite_m  <= 1'b0;
      apb_pwdata_m  <= '0;
      apb_psel_m    <= 1'b0;
      apb_penable_m <= 1'b0;
      rsp_vld_o     <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      if (load) {apb_pwrite_m, apb_paddr_m, apb_pwdata_m} <= head;
      case (state)
        ST_IDLE: state <= empty ? ST_IDLE : ST_SETUP;
        ST_SETUP: begin
          apb_psel_m <= 1'b1;
          state      <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (!apb_penable_m) apb_penable_m <= 1'b1;
          else if (apb_pready_m || tmo) begin
            apb_psel_m    <= 1'b0;
            apb_penable_m <= 1'b0;
            rsp_vld_o     <= 1'b1;
            rsp_rdata_o   <= (apb_pready_m && !apb_pwrite_m) ? apb_prdata_m : '0;
            rsp_timeout_o <= !apb_pready_m;
            tcnt          <= '0;
            state         <= ST_RESP;
          end else tcnt <= tcnt + TW'(1);
        end
        default: begin
          if (rsp_rdy_i) begin
            rsp_vld_o <= 1'b0;
            state     <= empty ? ST_IDLE : ST_SETUP;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: table rows, directed corner sequences and random traffic against an APB slave model
module tb_apb_cmd_master;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            wt;
    logic [DW-1:0] rd;
  } plan_t;
  typedef struct {
    logic [DW-1:0] rd;
    logic          to;
  } rsp_t;
  typedef struct {
    plan_t         p;
    logic [DW-1:0] exp_rd;
    logic          exp_to;
    int            exp_pen;
  } row_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_vld = 1'b0, cmd_rdy, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_vld, rsp_rdy = 1'b1, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready = 1'b0;
  logic [DW-1:0] pwdata, prdata = '0;

  int            total = 0, bad = 0, nrsp = 0, cyc = 0, hs_cyc = 0, last_gap = 0, acc = 0;
  logic          rnd_mode = 1'b0, rdy_force = 1'b1, last_to;
  logic [DW-1:0] last_rd;
  plan_t         drv, cur;
  plan_t         cmd_q[$];
  rsp_t          exp_q[$];
  row_t          rows[6];

  always #5 clk = ~clk;

  apb_cmd_master #(.BUS_AW(AW), .BUS_DW(DW), .CMD_DEPTH(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_rdata_o(rsp_rdata), .rsp_timeout_o(rsp_timeout),
    .apb_paddr_m(paddr), .apb_pwrite_m(pwrite), .apb_psel_m(psel), .apb_penable_m(penable),
    .apb_pwdata_m(pwdata), .apb_prdata_m(prdata), .apb_pready_m(pready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each command yields one response: aborted after TO ACCESS cycles without pready, else read data or 0.
  function automatic rsp_t model(input plan_t p);
    rsp_t r;
    r.to = (p.wt >= TO);
    r.rd = (r.to || p.w) ? '0 : p.rd;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rsp_rdy = rnd_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Slave model plus acceptance and response monitors, all sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pready = 1'b0;
      acc = 0;
    end else begin
      if (cmd_vld && cmd_rdy) begin
        cmd_q.push_back(drv);
        exp_q.push_back(model(drv));
      end
      if (psel && !penable) begin
        chk("setup_has_cmd", 64'(cmd_q.size() != 0), 1);
        if (cmd_q.size() != 0) begin
          cur = cmd_q.pop_front();
          chk("setup_paddr", 64'(paddr), 64'(cur.a));
          chk("setup_pwrite", 64'(pwrite), 64'(cur.w));
          if (cur.w) chk("setup_pwdata", 64'(pwdata), 64'(cur.d));
        end
        last_gap = cyc - hs_cyc;
        acc = 0;
        pready = 1'b0;
      end else if (psel && penable) begin
        chk("access_paddr", 64'(paddr), 64'(cur.a));
        pready = (acc == cur.wt);
        prdata = pready ? cur.rd : DW'($urandom);
        acc++;
      end else pready = 1'b0;
      if (rsp_vld && rsp_rdy) begin
        rsp_t e;
        chk("rsp_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
        last_rd = rsp_rdata;
        last_to = rsp_timeout;
        hs_cyc = cyc;
        nrsp++;
      end
    end
  end

  task automatic send(input plan_t p);
    int n;
    n = 0;
    drv = p;
    cmd_vld = 1'b1;
    cmd_write = p.w;
    cmd_addr = p.a;
    cmd_wdata = p.d;
    forever begin
      @(negedge clk);
      if (cmd_rdy || n > 300) break;
      n++;
    end
    chk("cmd_accept", 64'(cmd_rdy), 1);
    @(posedge clk);
    #1 cmd_vld = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_pending", 64'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    plan_t p;
    logic [DW-1:0] held;
    int n;
    rows[0] = '{'{1'b0, 6'h10, 32'h0, 3, 32'h12345678}, 32'h12345678, 1'b0, 4};
    rows[1] = '{'{1'b0, 6'h3F, 32'h0, 8, 32'h0BADBAD0}, 32'h0, 1'b1, 8};
    rows[2] = '{'{1'b1, 6'h05, 32'hDEADBEEF, 0, 32'hFFFFFFFF}, 32'h0, 1'b0, 1};
    rows[3] = '{'{1'b1, 6'h2A, 32'h01020304, 10, 32'h0}, 32'h0, 1'b1, 8};
    rows[4] = '{'{1'b0, 6'h00, 32'h0, 7, 32'hA5A5A5A5}, 32'hA5A5A5A5, 1'b0, 8};
    rows[5] = '{'{1'b0, 6'h01, 32'h0, 1, 32'h00000001}, 32'h00000001, 1'b0, 2};

    repeat (3) @(negedge clk);
    chk("rst_cmd_rdy", 64'(cmd_rdy), 1);
    chk("rst_psel", 64'(psel), 0);
    chk("rst_penable", 64'(penable), 0);
    chk("rst_rsp_vld", 64'(rsp_vld), 0);
    chk("rst_paddr", 64'(paddr), 0);
    chk("rst_rdata", 64'(rsp_rdata), 0);
    chk("rst_timeout", 64'(rsp_timeout), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency from an idle block, immediate pready
    send('{1'b1, 6'h05, 32'hDEADBEEF, 0, 32'h0});
    @(negedge clk) chk("lat_e0_psel", 64'(psel), 0);
    @(negedge clk) chk("lat_e1_psel", 64'(psel), 0);
    @(negedge clk);
    chk("lat_e2_psel", 64'(psel), 1);
    chk("lat_e2_penable", 64'(penable), 0);
    chk("lat_e2_paddr", 64'(paddr), 64'h05);
    chk("lat_e2_pwrite", 64'(pwrite), 1);
    chk("lat_e2_pwdata", 64'(pwdata), 64'hDEADBEEF);
    @(negedge clk);
    chk("lat_e3_penable", 64'(penable), 1);
    chk("lat_e3_pwdata", 64'(pwdata), 64'hDEADBEEF);
    @(negedge clk);
    chk("lat_e4_rsp_vld", 64'(rsp_vld), 1);
    chk("lat_e4_psel", 64'(psel), 0);
    chk("lat_e4_rdata", 64'(rsp_rdata), 0);
    chk("lat_e4_timeout", 64'(rsp_timeout), 0);
    drain();

    foreach (rows[i]) begin
      send(rows[i].p);
      drain();
      chk("row_rdata", 64'(last_rd), 64'(rows[i].exp_rd));
      chk("row_timeout", 64'(last_to), 64'(rows[i].exp_to));
      chk("row_penable_cycles", 64'(acc), 64'(rows[i].exp_pen));
    end

    // back-to-back commands: FIFO fills, RESP chains straight into SETUP
    for (int i = 0; i < 4; i++) begin
      send('{1'b0, AW'(8 + i), 32'h0, 2, DW'(32'h100 + i)});
      if (i == 2) begin
        @(negedge clk) chk("b2b_full", 64'(cmd_rdy), 0);
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("b2b_no_idle_gap", 64'(last_gap), 2);

    // response stall
    rdy_force = 1'b0;
    send('{1'b0, 6'h11, 32'h0, 0, 32'hCAFE0001});
    send('{1'b1, 6'h12, 32'h55AA55AA, 1, 32'h0});
    send('{1'b0, 6'h13, 32'h0, 2, 32'hCAFE0003});
    n = 0;
    while (!rsp_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_vld_seen", 64'(rsp_vld), 1);
    held = rsp_rdata;
    chk("stall_first_rdata", 64'(held), 64'hCAFE0001);
    repeat (5) begin
      @(negedge clk);
      chk("stall_rsp_vld", 64'(rsp_vld), 1);
      chk("stall_rdata_hold", 64'(rsp_rdata), 64'(held));
      chk("stall_psel", 64'(psel), 0);
      chk("stall_cmd_rdy", 64'(cmd_rdy), 0);
    end
    rdy_force = 1'b1;
    drain();

    // asynchronous reset in the middle of ACCESS
    send('{1'b0, 6'h20, 32'h0, 20, 32'h0});
    n = 0;
    while (!penable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_access_reached", 64'(penable), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 64'(psel), 0);
    chk("mid_rst_penable", 64'(penable), 0);
    chk("mid_rst_rsp_vld", 64'(rsp_vld), 0);
    chk("mid_rst_cmd_rdy", 64'(cmd_rdy), 1);
    cmd_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n = nrsp;
    send('{1'b1, 6'h07, 32'h13579BDF, 1, 32'h0});
    drain();
    chk("post_rst_rsp_count", 64'(nrsp - n), 1);
    chk("post_rst_rdata", 64'(last_rd), 0);
    chk("post_rst_timeout", 64'(last_to), 0);

    // random traffic with random response back-pressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      p.w = 1'($urandom_range(0, 1));
      p.a = AW'($urandom);
      p.d = DW'($urandom);
      p.wt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 3));
      p.rd = DW'($urandom);
      send(p);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
